// File: rtl/gates_bist.sv
// ---------------------------------------------------------------------------
// gates_bist
//   Built-in self-test controller for the two-input gate block. It walks the
//   gate inputs {b,a} through 00, 01, 10, 11, lets each vector settle for
//   SETTLE_CYCLES clocks, then checks y_and/y_or/y_xor against a&b, a|b and
//   a^b. It reports pass/fail, an error count and the first failing vector.
//
// Parameters
//   SETTLE_CYCLES  cycles between driving a vector and sampling (1..15)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle run request (ignored while busy)
//   y_and/or/xor in  gate block outputs (treated as combinational)
//   a, b        out  registered gate block inputs
//   busy        out  sequence in progress
//   done        out  sequence finished, held until next start/rst
//   pass        out  valid with done: no failing vectors
//   err_count   out  number of failing vectors in the last run (0..4)
//   fail_valid  out  a failure has been captured in this run
//   fail_vec    out  {b,a} of the first failing vector
//   fail_bits   out  {xor_mis, or_mis, and_mis} of the first failing vector
// ---------------------------------------------------------------------------
module gates_bist #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_and,
    input  logic       y_or,
    input  logic       y_xor,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       fail_valid,
    output logic [1:0] fail_vec,
    output logic [2:0] fail_bits
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_vec;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic       r_fvld;
    logic [1:0] r_fvec;
    logic [2:0] r_fbits;

    logic [2:0] w_mis;
    logic [2:0] w_err_nxt;

    // Expected values come from the registered a/b, which is exactly what
    // the gate block has been seeing for the whole settle window.
    assign w_mis     = {y_xor ^ (r_a ^ r_b), y_or ^ (r_a | r_b), y_and ^ (r_a & r_b)};
    assign w_err_nxt = r_err + {2'b00, |w_mis};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vec   <= 2'd0;
            r_cnt   <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_fvld  <= 1'b0;
            r_fvec  <= 2'd0;
            r_fbits <= 3'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    // a/b are left alone here so they hold the last vector.
                    if (start) begin
                        r_state <= SETTLE;
                        r_vec   <= 2'd0;
                        r_cnt   <= 4'd0;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= 3'd0;
                        r_fvld  <= 1'b0;
                        r_fvec  <= 2'd0;
                        r_fbits <= 3'd0;
                    end
                end
                SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == CNT_LAST)
                        r_state <= CHECK;
                end
                CHECK: begin
                    r_err <= w_err_nxt;
                    // Only the first failure of a run is captured.
                    if (|w_mis && !r_fvld) begin
                        r_fvld  <= 1'b1;
                        r_fvec  <= {r_b, r_a};
                        r_fbits <= w_mis;
                    end
                    if (r_vec == 2'd3) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == 3'd0);
                    end else begin
                        r_state      <= SETTLE;
                        r_vec        <= r_vec + 2'd1;
                        {r_b, r_a}   <= r_vec + 2'd1;
                        r_cnt        <= 4'd0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fvld;
    assign fail_vec   = r_fvec;
    assign fail_bits  = r_fbits;

endmodule
